// File: rtl/stats_pkg.sv
// Shared types and helpers for the per-port statistics block.
//   stats_kind_e : counter kind within a port (ACCEPT / DROP); the dump word
//                  index is {port, kind}.
//   dump_state_e : read-out FSM states.
//   sat_add      : saturating add at a caller-chosen width (<= 32 bits),
//                  returns {sat, value}.
//   SW_*         : default sizing inherited from the switch configuration.
package stats_pkg;

    localparam int unsigned SW_NUM_PORTS    = 4;
    localparam int unsigned SW_TARGET_WIDTH = SW_NUM_PORTS;
    localparam int unsigned SW_CNT_WIDTH    = 16;
    localparam int unsigned SAT_MAX_WIDTH   = 32;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } stats_kind_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_e;

    typedef struct packed {
        logic        sat;
        logic [31:0] value;
    } sat_add_t;

    // Sum is formed one bit wider than the operands so a carry out of the
    // 32-bit case is still seen as overflow.
    function automatic sat_add_t sat_add(input logic [31:0] cnt,
                                         input logic [31:0] inc,
                                         input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, cnt} + {1'b0, inc};
        max_val = (33'd1 << width) - 33'd1;
        if (sum > max_val) begin
            sat_add.sat   = 1'b1;
            sat_add.value = max_val[31:0];
        end else begin
            sat_add.sat   = 1'b0;
            sat_add.value = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/stats_cell.sv
// One statistics cell: saturating live counter, shadow (snapshot) register
// and sticky saturation flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : increment applied this cycle (0 when no event)
//   clear      : zero the live counter and sticky flag (this cycle's inc kept)
//   snap       : copy live value (pre-increment) into shadow
//   shadow     : captured counter value
//   sat_flag   : sticky saturation flag
module stats_cell
    import stats_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = SW_CNT_WIDTH,
    parameter int unsigned INC_WIDTH     = 3,
    parameter int unsigned CLEAR_ON_SNAP = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INC_WIDTH-1:0] inc,
    input  logic                 clear,
    input  logic                 snap,
    output logic [CNT_WIDTH-1:0] shadow,
    output logic                 sat_flag
);

    logic [CNT_WIDTH-1:0] live_q;
    logic [CNT_WIDTH-1:0] base;
    logic [CNT_WIDTH-1:0] next_val;
    sat_add_t             res;
    logic                 sat_now;

    // Clear or clearing snapshot restart from zero, so the current event
    // still lands in the fresh count.
    always_comb begin
        base = live_q;
        if (clear || (snap && (CLEAR_ON_SNAP != 0))) begin
            base = '0;
        end
        res = sat_add(32'(base), 32'(inc), CNT_WIDTH);
    end

    // Upper result bits are zero whenever the width is honoured; folding
    // them into the overflow test is a free guard.
    if (CNT_WIDTH < SAT_MAX_WIDTH) begin : g_narrow
        assign sat_now = res.sat | (|res.value[SAT_MAX_WIDTH-1:CNT_WIDTH]);
    end else begin : g_full
        assign sat_now = res.sat;
    end

    assign next_val = res.value[CNT_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            shadow   <= '0;
            sat_flag <= 1'b0;
        end else begin
            live_q <= next_val;
            if (snap) begin
                shadow <= live_q;
            end
            if (clear) begin
                sat_flag <= 1'b0;
            end else if (sat_now) begin
                sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_stats_collector.sv
// Per-port traffic statistics: counts accepted and dropped packets per
// ingress port (optionally weighted by fan-out), captures all counters
// atomically on snapshot and streams the snapshot out over valid/ready.
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid_in    : per-port packet offered
//   fifo_full   : per-port input FIFO full (offer counted as DROP)
//   target_in   : per-port target bitmap, port p at [p*TARGET_WIDTH +: TARGET_WIDTH]
//   snap_req    : capture live counters into shadow (ignored while busy)
//   clear_req   : zero live counters and sticky flags
//   dump_req    : start serial read-out of shadow registers (ignored while busy)
//   dump_valid, dump_ready, dump_data, dump_tag, dump_last : read-out stream,
//                 tag = {port, kind}, kind 0 = ACCEPT, 1 = DROP
//   busy        : dump in progress
//   sat_flag    : sticky saturation flags, index p*2+kind
module port_stats_collector
    import stats_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = SW_NUM_PORTS,
    parameter int unsigned TARGET_WIDTH  = SW_TARGET_WIDTH,
    parameter int unsigned CNT_WIDTH     = SW_CNT_WIDTH,
    parameter int unsigned WEIGHTED      = 1,
    parameter int unsigned CLEAR_ON_SNAP = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              valid_in,
    input  logic [NUM_PORTS-1:0]              fifo_full,
    input  logic [NUM_PORTS*TARGET_WIDTH-1:0] target_in,
    input  logic                              snap_req,
    input  logic                              clear_req,
    input  logic                              dump_req,
    output logic                              dump_valid,
    input  logic                              dump_ready,
    output logic [CNT_WIDTH-1:0]              dump_data,
    output logic [$clog2(NUM_PORTS):0]        dump_tag,
    output logic                              dump_last,
    output logic                              busy,
    output logic [2*NUM_PORTS-1:0]            sat_flag
);

    localparam int unsigned NUM_WORDS = 2 * NUM_PORTS;
    localparam int unsigned TAG_WIDTH = $clog2(NUM_PORTS) + 1;
    localparam int unsigned INC_WIDTH = $clog2(TARGET_WIDTH + 1);
    localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(NUM_WORDS - 1);

    logic [CNT_WIDTH-1:0] shadow [NUM_WORDS];
    logic                 snap_go;
    dump_state_e          state;

    // Shadows must stay frozen while they are being streamed out.
    assign snap_go = snap_req & ~busy;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [TARGET_WIDTH-1:0] tgt;
        logic [INC_WIDTH-1:0]    weight;
        logic [INC_WIDTH-1:0]    inc_acc;
        logic [INC_WIDTH-1:0]    inc_drop;
        logic                    accept;
        logic                    drop;

        assign tgt    = target_in[p*TARGET_WIDTH +: TARGET_WIDTH];
        assign accept = valid_in[p] & ~fifo_full[p];
        assign drop   = valid_in[p] & fifo_full[p];

        always_comb begin
            weight = INC_WIDTH'(1);
            if (WEIGHTED != 0) begin
                weight = INC_WIDTH'($countones(tgt));
            end
        end

        assign inc_acc  = accept ? weight : '0;
        assign inc_drop = drop   ? weight : '0;

        stats_cell #(
            .CNT_WIDTH     (CNT_WIDTH),
            .INC_WIDTH     (INC_WIDTH),
            .CLEAR_ON_SNAP (CLEAR_ON_SNAP)
        ) u_acc (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (inc_acc),
            .clear    (clear_req),
            .snap     (snap_go),
            .shadow   (shadow[2*p + ACCEPT]),
            .sat_flag (sat_flag[2*p + ACCEPT])
        );

        stats_cell #(
            .CNT_WIDTH     (CNT_WIDTH),
            .INC_WIDTH     (INC_WIDTH),
            .CLEAR_ON_SNAP (CLEAR_ON_SNAP)
        ) u_drop (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (inc_drop),
            .clear    (clear_req),
            .snap     (snap_go),
            .shadow   (shadow[2*p + DROP]),
            .sat_flag (sat_flag[2*p + DROP])
        );
    end

    // dump_tag doubles as the word index since word = {port, kind}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dump_valid <= 1'b0;
            busy       <= 1'b0;
            dump_last  <= 1'b0;
            dump_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        state      <= SEND;
                        dump_valid <= 1'b1;
                        busy       <= 1'b1;
                        dump_tag   <= '0;
                        dump_last  <= (LAST_TAG == '0);
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        if (dump_tag == LAST_TAG) begin
                            state      <= IDLE;
                            dump_valid <= 1'b0;
                            busy       <= 1'b0;
                            dump_last  <= 1'b0;
                            dump_tag   <= '0;
                        end else begin
                            dump_tag  <= dump_tag + TAG_WIDTH'(1);
                            dump_last <= ((dump_tag + TAG_WIDTH'(1)) == LAST_TAG);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    busy       <= 1'b0;
                    dump_last  <= 1'b0;
                    dump_tag   <= '0;
                end
            endcase
        end
    end

    // Shadows cannot change while busy, so the selected word is stable
    // for as long as the consumer stalls.
    assign dump_data = dump_valid ? shadow[dump_tag] : '0;

endmodule

// File: tb/tb_port_stats_collector.sv
module tb_port_stats_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid_in;
    logic [3:0]  fifo_full;
    logic [15:0] target_in;
    logic        snap_req;
    logic        clear_req;
    logic        dump_req;
    logic        dump_ready;

    // A: defaults (weighted, 16-bit); B: unweighted; C: 4-bit counters
    logic        a_valid, a_last, a_busy;
    logic [15:0] a_data;
    logic [2:0]  a_tag;
    logic [7:0]  a_sat;
    logic        b_valid, b_last, b_busy;
    logic [15:0] b_data;
    logic [2:0]  b_tag;
    logic [7:0]  b_sat;
    logic        c_valid, c_last, c_busy;
    logic [3:0]  c_data;
    logic [2:0]  c_tag;
    logic [7:0]  c_sat;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    int unsigned exp_a [8];
    int unsigned exp_b [8];
    int unsigned exp_c [8];

    always #5 clk = ~clk;

    port_stats_collector #(.NUM_PORTS(4), .TARGET_WIDTH(4), .CNT_WIDTH(16),
                           .WEIGHTED(1), .CLEAR_ON_SNAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .fifo_full(fifo_full),
        .target_in(target_in), .snap_req(snap_req), .clear_req(clear_req),
        .dump_req(dump_req), .dump_valid(a_valid), .dump_ready(dump_ready),
        .dump_data(a_data), .dump_tag(a_tag), .dump_last(a_last),
        .busy(a_busy), .sat_flag(a_sat)
    );

    port_stats_collector #(.NUM_PORTS(4), .TARGET_WIDTH(4), .CNT_WIDTH(16),
                           .WEIGHTED(0), .CLEAR_ON_SNAP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .fifo_full(fifo_full),
        .target_in(target_in), .snap_req(snap_req), .clear_req(clear_req),
        .dump_req(dump_req), .dump_valid(b_valid), .dump_ready(dump_ready),
        .dump_data(b_data), .dump_tag(b_tag), .dump_last(b_last),
        .busy(b_busy), .sat_flag(b_sat)
    );

    port_stats_collector #(.NUM_PORTS(4), .TARGET_WIDTH(4), .CNT_WIDTH(4),
                           .WEIGHTED(1), .CLEAR_ON_SNAP(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .fifo_full(fifo_full),
        .target_in(target_in), .snap_req(snap_req), .clear_req(clear_req),
        .dump_req(dump_req), .dump_valid(c_valid), .dump_ready(dump_ready),
        .dump_data(c_data), .dump_tag(c_tag), .dump_last(c_last),
        .busy(c_busy), .sat_flag(c_sat)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 8; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
            exp_c[i] = 0;
        end
    endtask

    task automatic pulse_snap();
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
    endtask

    task automatic check_word(input string name, input int i);
        chk($sformatf("%s.valid%0d", name, i), {31'd0, a_valid}, 32'd1);
        chk($sformatf("%s.tag%0d", name, i), {29'd0, a_tag}, i);
        chk($sformatf("%s.last%0d", name, i), {31'd0, a_last}, (i == 7) ? 32'd1 : 32'd0);
        chk($sformatf("%s.a_data%0d", name, i), {16'd0, a_data}, exp_a[i]);
        chk($sformatf("%s.b_data%0d", name, i), {16'd0, b_data}, exp_b[i]);
        chk($sformatf("%s.c_data%0d", name, i), {28'd0, c_data}, exp_c[i]);
    endtask

    task automatic do_dump(input string name);
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        cycle();
        dump_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_word(name, i);
            cycle();
        end
        chk({name, ".end_valid"}, {31'd0, a_valid}, 32'd0);
        chk({name, ".end_busy"}, {31'd0, a_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        valid_in   = '0;
        fifo_full  = '0;
        target_in  = '0;
        snap_req   = 1'b0;
        clear_req  = 1'b0;
        dump_req   = 1'b0;
        dump_ready = 1'b0;
        clr_exp();
        repeat (3) cycle();

        // reset state
        chk("rst.valid", {31'd0, a_valid}, 32'd0);
        chk("rst.busy",  {31'd0, a_busy},  32'd0);
        chk("rst.last",  {31'd0, a_last},  32'd0);
        chk("rst.tag",   {29'd0, a_tag},   32'd0);
        chk("rst.data",  {16'd0, a_data},  32'd0);
        chk("rst.sat",   {24'd0, a_sat},   32'd0);
        rst_n = 1'b1;
        cycle();

        // dump without any snapshot: zeros, back-to-back
        do_dump("nosnap");

        // port 0: 3 accepts of weight 3, 2 drops of weight 2
        valid_in  = 4'b0001;
        fifo_full = 4'b0000;
        target_in = 16'h000B;
        repeat (3) cycle();
        fifo_full = 4'b0001;
        target_in = 16'h0006;
        repeat (2) cycle();
        valid_in  = '0;
        fifo_full = '0;
        target_in = '0;
        pulse_snap();
        exp_a[0] = 9; exp_a[1] = 4;
        exp_b[0] = 3; exp_b[1] = 2;
        exp_c[0] = 9; exp_c[1] = 4;
        do_dump("p0");

        // port 2: 5 accepts of weight 4 -> saturates the 4-bit counter
        valid_in  = 4'b0100;
        target_in = 16'h0F00;
        repeat (5) cycle();
        valid_in  = '0;
        target_in = '0;
        cycle();
        chk("sat.c_set", {24'd0, c_sat}, 32'h10);
        chk("sat.a_none", {24'd0, a_sat}, 32'h00);
        pulse_snap();
        chk("sat.c_after_snap", {24'd0, c_sat}, 32'h10);
        clr_exp();
        exp_a[4] = 20; exp_b[4] = 5; exp_c[4] = 15;
        do_dump("sat");
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        chk("sat.c_cleared", {24'd0, c_sat}, 32'h00);

        // port 1: live = 7 then snapshot coincides with weight-2 accept
        valid_in  = 4'b0010;
        target_in = 16'h0070;
        cycle();
        target_in = 16'h0030;
        repeat (2) cycle();
        snap_req = 1'b1;
        cycle();
        snap_req  = 1'b0;
        valid_in  = '0;
        target_in = '0;
        clr_exp();
        exp_a[2] = 7; exp_b[2] = 3; exp_c[2] = 7;
        do_dump("coinc_shadow");
        pulse_snap();
        exp_a[2] = 2; exp_b[2] = 1; exp_c[2] = 2;
        do_dump("coinc_live");

        // distinct shadow contents for the stall test
        valid_in  = 4'b1001;
        fifo_full = 4'b1001;
        target_in = 16'h1007;
        cycle();
        valid_in  = 4'b0001;
        fifo_full = 4'b0000;
        target_in = 16'h000F;
        cycle();
        valid_in  = '0;
        target_in = '0;
        pulse_snap();
        clr_exp();
        exp_a[0] = 4; exp_b[0] = 1; exp_c[0] = 4;
        exp_a[1] = 3; exp_b[1] = 1; exp_c[1] = 3;
        exp_a[7] = 1; exp_b[7] = 1; exp_c[7] = 1;
        // live traffic after the snapshot; must not reach the shadows
        valid_in  = 4'b0001;
        target_in = 16'h0003;
        cycle();
        valid_in  = '0;
        target_in = '0;

        // dump with ready pattern 1,0,0,1 and a snap_req while busy
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        cycle();
        dump_req = 1'b0;
        check_word("stall", 0);
        cycle();
        check_word("stall_h0", 1);
        dump_ready = 1'b0;
        snap_req   = 1'b1;
        cycle();
        snap_req = 1'b0;
        check_word("stall_h1", 1);
        chk("stall.busy", {31'd0, a_busy}, 32'd1);
        cycle();
        check_word("stall_h2", 1);
        dump_ready = 1'b1;
        cycle();
        for (int i = 2; i < 8; i++) begin
            check_word("stall", i);
            cycle();
        end
        chk("stall.end_busy", {31'd0, a_busy}, 32'd0);
        do_dump("busy_snap_ignored");

        // reset after third handshake of a dump
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        cycle();
        dump_req = 1'b0;
        repeat (3) cycle();
        chk("rstmid.tag_before", {29'd0, a_tag}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid.valid", {31'd0, a_valid}, 32'd0);
        chk("rstmid.busy",  {31'd0, a_busy},  32'd0);
        chk("rstmid.tag",   {29'd0, a_tag},   32'd0);
        chk("rstmid.data",  {16'd0, a_data},  32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("rstmid.idle_valid", {31'd0, a_valid}, 32'd0);
        pulse_snap();
        clr_exp();
        do_dump("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/port_stats_collector.md
Name: port_stats_collector

Overview:
- Synthesizable per-port traffic statistics block for the N-port packet switch.
- Sits beside the port input FIFOs and counts accepted and dropped packets per ingress port, weighted by fan-out, with saturating counters.
- Software or the bench captures all counters atomically with a snapshot, then reads them out serially over a valid/ready stream.
- Generalises bench-side drop counting to hardware: any port count, any counter width, selectable weighting mode.

Parameters:
- NUM_PORTS, 4, number of ingress ports.
- TARGET_WIDTH, 4, width of the per-port target bitmap (one bit per egress port).
- CNT_WIDTH, 16, width of each counter.
- WEIGHTED, 1, 1 = increment by popcount(target), 0 = increment by 1 per packet.
- CLEAR_ON_SNAP, 1, 1 = live counters restart from the current-cycle increment on snapshot.

Ports:
- clk  in  1  single clock domain (all logic on rising edge).
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  NUM_PORTS  per-port packet offered at ingress.
- fifo_full  in  NUM_PORTS  per-port input FIFO full (offer is dropped).
- target_in  in  NUM_PORTS*TARGET_WIDTH  per-port target bitmap; port p occupies slice [p*TARGET_WIDTH +: TARGET_WIDTH].
- snap_req  in  1  one-cycle pulse: capture live counters into shadow registers.
- clear_req  in  1  one-cycle pulse: zero live counters and sticky flags.
- dump_req  in  1  one-cycle pulse: start a serial read-out of the shadow registers.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  consumer accepts the dump word.
- dump_data  out  CNT_WIDTH  shadow counter value.
- dump_tag  out  $clog2(NUM_PORTS)+1  {port index, kind}; kind 0 = ACCEPT, 1 = DROP.
- dump_last  out  1  marks the final word of a dump.
- busy  out  1  dump in progress.
- sat_flag  out  2*NUM_PORTS  sticky saturation flag, index p*2+kind.

Behaviour:
- Reset (async assert, synchronous deassert by the system): all live and shadow counters are 0, sat_flag = 0, dump_valid = 0, dump_last = 0, dump_data = 0, dump_tag = 0, busy = 0, FSM in IDLE.
- Event classification per port p per cycle:
  - accept = valid_in[p] & ~fifo_full[p].
  - drop = valid_in[p] & fifo_full[p].
  - inc = WEIGHTED ? popcount(target slice) : 1.
  - inc = 0 when target = 0 and WEIGHTED = 1.
- Counter update: registered, 1-cycle latency. new = cnt + inc, computed at CNT_WIDTH+1 bits. If the result exceeds 2^CNT_WIDTH-1, the counter holds all-ones and its sat_flag bit is set. sat_flag stays set until clear_req or reset.
- clear_req with an event in the same cycle: live counter = inc (saturated), sat_flag = 0. Events are never lost.
- snap_req: shadow = live value before this cycle's increment.
  - If CLEAR_ON_SNAP = 1, live = inc; otherwise live = live + inc.
  - snap_req while busy is ignored and the shadow registers are untouched.
  - snap_req and clear_req in the same cycle: the snapshot captures the pre-clear values, then the clear applies.
- Dump FSM:
  - IDLE: on dump_req go to SEND with index 0; busy = 1.
  - SEND: dump_valid = 1, dump_data = shadow[index], dump_tag = index. Word order is port 0 ACCEPT, port 0 DROP, port 1 ACCEPT, and so on. dump_last = 1 when index = 2*NUM_PORTS-1.
  - On dump_valid & dump_ready, advance the index. After the last word go to IDLE, deassert dump_valid and busy in the next cycle.
  - dump_data and dump_tag are held stable while dump_valid = 1 and dump_ready = 0.
  - dump_req while busy is ignored.
  - A dump with no prior snapshot outputs zeros.
- Live counting continues during a dump.
- Reset mid-dump aborts immediately: outputs return to their reset values and no further words are emitted.

Decomposition:
- Shared package (stats_pkg):
  - stats_kind_e {ACCEPT=0, DROP=1}.
  - dump_state_e {IDLE, SEND}.
  - Function sat_add(cnt, inc) returning {sat, value}.
  - Default constants for CNT_WIDTH and NUM_PORTS, derived from the switch package values.
- Sub-module stats_cell: one saturating live counter plus shadow register and sticky flag, with inputs inc, clear, snap.
  - The top instantiates 2*NUM_PORTS cells and contains the dump FSM and the mux.

Test Plan:
- Reset then dump_req without a snapshot, dump_ready = 1: 8 words of 0 on consecutive cycles, tags 0..7, dump_last only on tag 7.
- Port 0: 3 offers with target 4'b1011 and fifo_full = 0, then 2 offers with target 4'b0110 and fifo_full = 1; snap; dump: word0 (P0 ACC) = 9, word1 (P0 DROP) = 4. With WEIGHTED = 0: 3 and 2.
- CNT_WIDTH = 4: 5 offers with target 4'b1111 accepted on port 2, then snap: P2 ACC = 15, sat_flag[4] = 1. clear_req then clears the flag.
- snap_req on the same cycle as a port 1 accept of weight 2, with live = 7 and CLEAR_ON_SNAP = 1: shadow = 7, live = 2 the next cycle.
- dump_ready toggled 1,0,0,1 during a dump: word 1 is held stable for 3 cycles; snap_req while busy leaves the shadow registers unchanged.
- rst_n asserted after the third dump handshake: dump_valid and busy go 0 asynchronously, and all counters read 0 after release and snap.
